// File: rtl/scoot_world.sv
// scoot_world: pellet grid world that senses for and is steered by scootBot; SCOOT_WATCHDOG_EN adds a SENSE timeout.
// Minimum step is 2 cycles (COLLECT then SENSE); SENSE holds l* stable until move_valid (or the watchdog) completes the move.
module scoot_world #(
  parameter int WIDTH = 10,
  parameter int HEIGHT = 10,
  parameter int NUM_STEPS = 100,
  parameter logic [HEIGHT-1:0] INIT_COL = 10'b0010101001
`ifdef SCOOT_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mUp,
  input  logic mRight,
  input  logic mDown,
  input  logic mLeft,
  input  logic move_valid,
  output logic lUp,
  output logic lRight,
  output logic lDown,
  output logic lLeft,
  output logic sense_valid,
  output logic [$clog2(WIDTH)-1:0] pos_x,
  output logic [$clog2(HEIGHT)-1:0] pos_y,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] score,
  output logic [$clog2(NUM_STEPS+1)-1:0] step_count,
  output logic pickup,
  output logic busy,
  output logic done
`ifdef SCOOT_WATCHDOG_EN
  ,
  output logic wdog_fire
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = $clog2(WIDTH*HEIGHT+1);
  localparam int CW = $clog2(NUM_STEPS+1);
  localparam logic [XW-1:0] xMax = XW'(WIDTH - 1);
  localparam logic [YW-1:0] yMax = YW'(HEIGHT - 1);

  localparam logic [1:0] stIdle    = 2'd0;
  localparam logic [1:0] stCollect = 2'd1;
  localparam logic [1:0] stSense   = 2'd2;
  localparam logic [1:0] stDone    = 2'd3;

  logic [1:0]        state;
  logic [HEIGHT-1:0] grid [WIDTH];

  logic [XW-1:0] xInc, xDec, newX;
  logic [YW-1:0] yInc, yDec, newY;
  logic [CW-1:0] stepNext;
  logic          hereBit, take;
  logic          goUp, goDown, goRight, goLeft;

  assign xInc = (pos_x == xMax) ? '0 : pos_x + XW'(1);
  assign xDec = (pos_x == '0) ? xMax : pos_x - XW'(1);
  assign yInc = (pos_y == yMax) ? '0 : pos_y + YW'(1);
  assign yDec = (pos_y == '0) ? yMax : pos_y - YW'(1);

  assign hereBit = grid[pos_x][pos_y];

  // Opposing requests cancel; moves only count while move_valid is high, so a watchdog timeout is a zero move.
  assign goUp    = move_valid & mUp & ~mDown;
  assign goDown  = move_valid & mDown & ~mUp;
  assign goRight = move_valid & mRight & ~mLeft;
  assign goLeft  = move_valid & mLeft & ~mRight;

  assign newX = goRight ? xInc : (goLeft ? xDec : pos_x);
  assign newY = goUp ? yInc : (goDown ? yDec : pos_y);
  assign stepNext = step_count + CW'(1);

  assign sense_valid = (state == stSense);
  assign busy        = (state == stCollect) || (state == stSense);
  assign done        = (state == stDone);

`ifdef SCOOT_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdogCnt;
  logic          wdogHit;

  assign wdogHit = (state == stSense) && !move_valid && (wdogCnt == WW'(WDOG_CYCLES - 1));
  assign take    = (state == stSense) && (move_valid || wdogHit);

  always_ff @(posedge clk) begin
    if (reset) begin
      wdogCnt   <= '0;
      wdog_fire <= 1'b0;
    end else begin
      wdog_fire <= wdogHit;
      if (state != stSense || take) wdogCnt <= '0;
      else                          wdogCnt <= wdogCnt + WW'(1);
    end
  end
`else
  assign take = (state == stSense) && move_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= stIdle;
      for (int i = 0; i < WIDTH; i++) grid[i] <= INIT_COL;
      pos_x      <= XW'(WIDTH / 2);
      pos_y      <= YW'(HEIGHT / 2);
      score      <= '0;
      step_count <= '0;
      pickup     <= 1'b0;
      lUp        <= 1'b0;
      lRight     <= 1'b0;
      lDown      <= 1'b0;
      lLeft      <= 1'b0;
    end else begin
      pickup <= 1'b0;
      case (state)
        stIdle: begin
          if (start) state <= stCollect;
        end
        stCollect: begin
          if (hereBit) begin
            grid[pos_x][pos_y] <= 1'b0;
            pickup             <= 1'b1;
            if (score != '1) score <= score + SW'(1);
          end
          // Sense lines see the post-clear grid; the mask matters only for a 1-wide or 1-high world.
          lUp    <= grid[pos_x][yInc] & (yInc != pos_y);
          lDown  <= grid[pos_x][yDec] & (yDec != pos_y);
          lRight <= grid[xInc][pos_y] & (xInc != pos_x);
          lLeft  <= grid[xDec][pos_y] & (xDec != pos_x);
          state  <= stSense;
        end
        stSense: begin
          if (take) begin
            pos_x      <= newX;
            pos_y      <= newY;
            step_count <= stepNext;
            state      <= (stepNext == CW'(NUM_STEPS)) ? stDone : stCollect;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scoot_world.sv
// Bench for scoot_world: move table checked through an expected-result queue, plus wrap/done/reset/hold sequences.
module tb_scoot_world;

  logic clk = 1'b0;
  logic reset, start, mUp, mRight, mDown, mLeft, move_valid;
  logic lUp, lRight, lDown, lLeft, sense_valid, pickup, busy, done;
  logic [3:0] pos_x, pos_y;
  logic [6:0] score, step_count;
`ifdef SCOOT_WATCHDOG_EN
  logic wdog_fire;
`endif

  always #5 clk = ~clk;

  scoot_world dut (
    .clk(clk), .reset(reset), .start(start),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft), .move_valid(move_valid),
    .lUp(lUp), .lRight(lRight), .lDown(lDown), .lLeft(lLeft),
    .sense_valid(sense_valid), .pos_x(pos_x), .pos_y(pos_y),
    .score(score), .step_count(step_count),
    .pickup(pickup), .busy(busy), .done(done)
`ifdef SCOOT_WATCHDOG_EN
    , .wdog_fire(wdog_fire)
`endif
  );

  typedef struct packed {
    logic u, r, d, l;
    int   x, y, sc, st;
    logic pk, eu, er, ed, el;
  } vec_t;

  vec_t tbl [19];
  vec_t expQ [$];
  int   nVec = 0;
  int   nMiss = 0;

  function automatic vec_t mk(input logic u, r, d, l, input int x, y, sc, st,
                              input logic pk, eu, er, ed, el);
    vec_t v;
    v.u = u; v.r = r; v.d = d; v.l = l;
    v.x = x; v.y = y; v.sc = sc; v.st = st;
    v.pk = pk; v.eu = eu; v.er = er; v.ed = ed; v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nVec++;
    if (act !== want) begin
      nMiss++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic waitSense(input string nm);
    int n = 0;
    while (!sense_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " sense_valid within bound"}, 32'(sense_valid), 1);
  endtask

  task automatic chkOut(input string nm, input vec_t e);
    chk({nm, " pos_x"}, 32'(pos_x), e.x);
    chk({nm, " pos_y"}, 32'(pos_y), e.y);
    chk({nm, " score"}, 32'(score), e.sc);
    chk({nm, " step_count"}, 32'(step_count), e.st);
    chk({nm, " pickup"}, 32'(pickup), 32'(e.pk));
    chk({nm, " l{U,R,D,L}"}, {28'd0, lUp, lRight, lDown, lLeft}, {28'd0, e.eu, e.er, e.ed, e.el});
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t e;
    int   cyc;

    tbl[0]  = mk(0,1,0,0, 6,5,2,1,  1, 0,1,0,0);
    tbl[1]  = mk(0,0,1,0, 6,4,2,2,  0, 0,0,1,0);
    tbl[2]  = mk(0,0,1,0, 6,3,3,3,  1, 0,1,0,1);
    tbl[3]  = mk(0,0,1,0, 6,2,3,4,  0, 0,0,0,0);
    tbl[4]  = mk(0,0,1,0, 6,1,3,5,  0, 0,0,1,0);
    tbl[5]  = mk(0,0,1,0, 6,0,4,6,  1, 0,1,0,1);
    tbl[6]  = mk(0,0,1,0, 6,9,4,7,  0, 0,0,0,0);
    tbl[7]  = mk(0,0,0,1, 5,9,4,8,  0, 1,0,0,0);
    tbl[8]  = mk(0,0,0,1, 4,9,4,9,  0, 1,0,0,0);
    tbl[9]  = mk(0,0,0,1, 3,9,4,10, 0, 1,0,0,0);
    tbl[10] = mk(0,0,0,1, 2,9,4,11, 0, 1,0,0,0);
    tbl[11] = mk(0,0,0,1, 1,9,4,12, 0, 1,0,0,0);
    tbl[12] = mk(0,0,0,1, 0,9,4,13, 0, 1,0,0,0);
    tbl[13] = mk(0,0,0,1, 9,9,4,14, 0, 1,0,0,0);
    tbl[14] = mk(1,1,1,1, 9,9,4,15, 0, 1,0,0,0);
    tbl[15] = mk(1,0,0,0, 9,0,5,16, 1, 0,1,0,1);
    tbl[16] = mk(1,1,0,0, 0,1,5,17, 0, 0,0,1,0);
    tbl[17] = mk(0,0,1,1, 9,0,5,18, 0, 0,1,0,1);
    tbl[18] = mk(1,1,1,0, 0,0,6,19, 1, 0,1,0,0);

    reset = 1'b1; start = 1'b0; move_valid = 1'b0;
    mUp = 1'b0; mRight = 1'b0; mDown = 1'b0; mLeft = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chkOut("reset", mk(0,0,0,0, 5,5,0,0, 0, 0,0,0,0));
    chk("reset flags {sense,busy,done}", {29'd0, sense_valid, busy, done}, 0);
    reset = 1'b0;

    // move_valid in IDLE must not start anything
    move_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle ignores move_valid busy", 32'(busy), 0);
    chk("idle ignores move_valid step", 32'(step_count), 0);
    move_valid = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first COLLECT busy", 32'(busy), 1);
    chk("first COLLECT sense_valid", 32'(sense_valid), 0);
    @(negedge clk);
    chk("first SENSE sense_valid", 32'(sense_valid), 1);
    chkOut("first collect", mk(0,0,0,0, 5,5,1,0, 1, 0,1,0,1));
    @(negedge clk);
    chk("pickup is one cycle", 32'(pickup), 0);

    for (int i = 0; i < 19; i++) begin
      mUp = tbl[i].u; mRight = tbl[i].r; mDown = tbl[i].d; mLeft = tbl[i].l;
      move_valid = 1'b1;
      expQ.push_back(tbl[i]);
      @(negedge clk);
      move_valid = 1'b0;
      mUp = 1'b0; mRight = 1'b0; mDown = 1'b0; mLeft = 1'b0;
      chk($sformatf("vec%0d COLLECT gap", i), 32'(sense_valid), 0);
      waitSense($sformatf("vec%0d", i));
      e = expQ.pop_front();
      chkOut($sformatf("vec%0d", i), e);
    end

`ifdef SCOOT_WATCHDOG_EN
    cyc = 0;
    while (!wdog_fire && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("watchdog fire cycle", cyc, 16);
    chk("watchdog step_count", 32'(step_count), 20);
    chk("watchdog pos_x", 32'(pos_x), 0);
    chk("watchdog pos_y", 32'(pos_y), 0);
    @(negedge clk);
    chk("watchdog pulse width", 32'(wdog_fire), 0);
`else
    repeat (40) @(negedge clk);
    chk("hold sense_valid", 32'(sense_valid), 1);
    chk("hold step_count", 32'(step_count), 19);
    chk("hold lRight stable", 32'(lRight), 1);
`endif

    // Zero-move run with move_valid and start held high throughout
    pulseReset();
    chk("rerun reset score", 32'(score), 0);
    chk("rerun reset done", 32'(done), 0);
    start = 1'b1; move_valid = 1'b1;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("cycles to done at 2-cycle step", cyc, 201);
    chk("done step_count", 32'(step_count), 100);
    chk("done score", 32'(score), 1);
    chk("done pos", {pos_x, pos_y}, {4'd5, 4'd5});
    chk("done flags {sense,busy}", {30'd0, sense_valid, busy}, 0);
    repeat (5) @(negedge clk);
    chk("done holds", {24'd0, done, step_count}, {24'd0, 1'b1, 7'd100});
    chk("done score frozen", 32'(score), 1);
    start = 1'b0; move_valid = 1'b0;

    // Reset mid-run after 40 right moves
    pulseReset();
    start = 1'b1; move_valid = 1'b1; mRight = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid-run step_count", 32'(step_count), 40);
    chk("mid-run score", 32'(score), 10);
    chk("mid-run pos_x", 32'(pos_x), 5);
    chk("mid-run busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-run reset step", 32'(step_count), 0);
    chk("mid-run reset score", 32'(score), 0);
    chk("mid-run reset busy", 32'(busy), 0);
    reset = 1'b0; move_valid = 1'b0; mRight = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("grid reloaded pickup", 32'(pickup), 1);
    chk("grid reloaded score", 32'(score), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/scoot_world.md
Name: scoot_world

Overview:
- Synthesizable grid-world engine paired with the scootBot controller.
- Holds the pellet grid and bot position, drives the bot's four sense lines, and consumes its four move lines.
- Clears and counts pellets at each visited cell, then ends the run after NUM_STEPS moves.
- Replaces the behavioural world loop so that bot and world run cycle-accurately on one clock.

Parameters:
- WIDTH, 10, grid columns (x range 0..WIDTH-1).
- HEIGHT, 10, grid rows (y range 0..HEIGHT-1).
- NUM_STEPS, 100, number of move handshakes per run.
- INIT_COL, 10'b0010101001, HEIGHT-bit pellet pattern loaded into every column; bit y = pellet at (x,y).
- WDOG_CYCLES, 16, watchdog limit; used only with SCOOT_WATCHDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE only.
- mUp, mRight, mDown, mLeft  in  1 each  move requests from the bot.
- move_valid  in  1  bot asserts when m* are valid.
- lUp, lRight, lDown, lLeft  out  1 each  pellet present in the neighbouring cell (wrapped).
- sense_valid  out  1  l* are valid; world is waiting for a move.
- pos_x  out  clog2(WIDTH)  current x.
- pos_y  out  clog2(HEIGHT)  current y.
- score  out  clog2(WIDTH*HEIGHT+1)  pellets collected.
- step_count  out  clog2(NUM_STEPS+1)  moves completed.
- pickup  out  1  one-cycle pulse when a pellet is cleared.
- busy  out  1  high in COLLECT/SENSE.
- done  out  1  high in DONE.

Behaviour:
- Reset is synchronous, active-high, and applies in any state, including mid-run:
  - state=IDLE; every column reloads INIT_COL.
  - pos=(WIDTH/2, HEIGHT/2); score=0; step_count=0.
  - pickup=0, sense_valid=0, busy=0, done=0, all l*=0.
- IDLE: on start=1, go to COLLECT next cycle.
- COLLECT (1 cycle):
  - If grid[pos_x][pos_y]=1, clear it, score+=1, and pulse pickup=1 in the following cycle.
  - Go to SENSE.
- SENSE:
  - sense_valid=1.
  - l* are registered from the post-clear grid:
    - lUp=grid[x][(y+1) mod H]; lDown=grid[x][(y-1) mod H].
    - lRight=grid[(x+1) mod W][y]; lLeft=grid[(x-1) mod W][y].
  - l* are held stable while waiting.
  - Handshake completes on the first cycle with sense_valid=1 and move_valid=1.
- Move update at handshake:
  - dx = mRight - mLeft; dy = mUp - mDown, each in {-1,0,+1}. Opposing pair both set = 0.
  - x = (x+dx) mod W; y = (y+dy) mod H. Wrap is true modulo: 0-1 gives W-1/H-1, never a negative index.
  - Diagonal moves are allowed.
  - step_count+=1.
  - If the new step_count == NUM_STEPS, go to DONE; else go to COLLECT.
  - sense_valid drops for at least the one COLLECT cycle, so minimum step period = 2 cycles.
- The last move's destination cell is not collected.
- DONE: done=1, all outputs frozen; start is ignored; only reset leaves DONE.
- move_valid outside SENSE is ignored.
- start while busy is ignored.
- score saturates at its maximum (unreachable with a legal grid, but required).

Optional Feature:
- Macro SCOOT_WATCHDOG_EN.
- When defined:
  - A counter runs in SENSE.
  - If move_valid has not arrived after WDOG_CYCLES cycles, the handshake completes as a zero move (dx=dy=0).
  - step_count still increments, and output wdog_fire (1-bit) pulses for one cycle.
- When undefined:
  - SENSE waits indefinitely.
  - No counter logic; wdog_fire port is absent.

Test Plan:
- Reset then start with defaults → at first COLLECT (5,5) holds a pellet: pickup pulse, score=1; in SENSE lUp=0, lDown=0, lRight=1, lLeft=1.
- From (5,5) handshake mRight=1 → pos=(6,5), next COLLECT score=2, step_count=1.
- Move mDown five times from y=5 → y=0 on the fifth move (pellet at y=0 collected); next mDown → y=9; then mLeft repeatedly from x=6 wraps 0→9.
- Hold mUp=mDown=1 and mLeft=mRight=1 on a handshake → pos unchanged, step_count increments, no pickup.
- Bot answers 100 zero moves → done=1 after step 100, step_count=100, score=1, further move_valid/start ignored; reset asserted at step 40 of a rerun → IDLE, grid reloaded, score=0.
- With SCOOT_WATCHDOG_EN, WDOG_CYCLES=16: hold move_valid=0 in SENSE → wdog_fire pulse at cycle 16, pos unchanged, step_count+1; without the macro, the same stimulus leaves sense_valid high indefinitely.
